video_fetch_ctrl: RTL and testbench

Schedules framebuffer reads for the bitplane video output. It issues single-word bus read handshakes in bursts to keep the pixel FIFO topped up, and restarts the frame at the base address on every frame start. The block sits between the shared memory bus and the pixel FIFO whose read side feeds the 8-pixel shift registers. One 32-bit word carries red, green, blue and bright bytes for 8 pixels.

---
 rtl/video_fetch_ctrl.sv | 163 ++++++++++++++++
 tb/tb_video_fetch_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_fetch_ctrl.sv
// Framebuffer fetch scheduler: issues single-word bus reads in bursts to keep the
// pixel FIFO topped up, restarting at base_addr on every frame_start.
module video_fetch_ctrl #(
  parameter int addr_bits   = 30,
  parameter int fifo_aw     = 9,
  parameter int burst_len   = 8,
  parameter int frame_words = 38400
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [addr_bits-1:0] base_addr,
  input  logic                 frame_start,
  input  logic [fifo_aw:0]     fifo_level,
  output logic                 fifo_clear,
  output logic                 fifo_wr,
  output logic [31:0]          fifo_wdata,
  output logic                 bus_req,
  output logic [addr_bits-1:0] bus_addr,
  input  logic                 bus_ack,
  input  logic [31:0]          bus_rdata,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int WC_W = $clog2(frame_words + 1);
  localparam int BC_W = (burst_len > 1) ? $clog2(burst_len) : 1;
  localparam logic [fifo_aw:0] DEPTH     = {1'b1, {fifo_aw{1'b0}}};
  localparam logic [WC_W-1:0]  FRAME_END = WC_W'(frame_words);
  localparam logic [BC_W-1:0]  BEAT_LAST = BC_W'(burst_len - 1);
  localparam logic [31:0]      BURST_W   = 32'(burst_len);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ROOM  = 3'd1,
    BURST = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [addr_bits-1:0] addr;
  logic [WC_W-1:0]      word_cnt;
  logic [BC_W-1:0]      beat_cnt;
  logic                 restart;
  logic                 beat_clr;
  logic                 vld_p0;
  logic                 vld_p1;
  logic                 clr_p1;
  logic [31:0]          wdata_p1;
  logic [fifo_aw:0]     room;
  logic [31:0]          room_w;
  logic [31:0]          remain_w;
  logic [31:0]          bsize_w;
  logic                 last_beat;

  // While the clear pulse is out the FIFO is emptied before any write of the new burst lands.
  always_comb begin
    room     = fifo_clear ? DEPTH : (DEPTH - fifo_level);
    room_w   = 32'(room);
    remain_w = 32'(FRAME_END - word_cnt);
    bsize_w  = (remain_w < BURST_W) ? remain_w : BURST_W;
  end

  assign last_beat = (beat_cnt == BEAT_LAST) || (word_cnt == (FRAME_END - WC_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    beat_clr  = 1'b0;
    vld_p0    = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start && enable) begin
          restart   = 1'b1;
          state_nxt = ROOM;
        end
      end
      ROOM, DONE: begin
        if (frame_start && enable) begin
          restart   = 1'b1;
          state_nxt = ROOM;
        end else if (!enable) begin
          state_nxt = IDLE;
        end else if (state == ROOM) begin
          if (word_cnt == FRAME_END) begin
            state_nxt = DONE;
          end else if (!fifo_wr && (room_w >= bsize_w)) begin
            beat_clr  = 1'b1;
            state_nxt = BURST;
          end
        end
      end
      BURST: begin
        // An abandoned read completing this cycle is dropped; otherwise it is drained in FLUSH.
        if (frame_start) begin
          if (bus_ack) begin
            restart   = enable;
            state_nxt = enable ? ROOM : IDLE;
          end else begin
            state_nxt = FLUSH;
          end
        end else if (bus_ack) begin
          vld_p0 = 1'b1;
          if (!enable)        state_nxt = IDLE;
          else if (last_beat) state_nxt = ROOM;
        end
      end
      FLUSH: begin
        if (bus_ack) begin
          restart   = enable;
          state_nxt = enable ? ROOM : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      word_cnt <= '0;
      beat_cnt <= '0;
    end else if (restart) begin
      addr     <= base_addr;
      word_cnt <= '0;
      beat_cnt <= '0;
    end else if (beat_clr) begin
      beat_cnt <= '0;
    end else if (vld_p0) begin
      addr     <= addr + addr_bits'(1);
      word_cnt <= word_cnt + WC_W'(1);
      beat_cnt <= beat_cnt + BC_W'(1);
    end
  end

  // p0 -> p1: accepted read data becomes a single-cycle FIFO write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      clr_p1   <= 1'b0;
      wdata_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      clr_p1 <= restart;
      if (vld_p0) wdata_p1 <= bus_rdata;
    end
  end

  assign fifo_wr    = vld_p1;
  assign fifo_wdata = wdata_p1;
  assign fifo_clear = clr_p1;
  assign bus_req    = (state == BURST) || (state == FLUSH);
  assign bus_addr   = addr;
  assign busy       = (state != IDLE) && (state != DONE);
  assign frame_done = (state == DONE);

endmodule

// File: tb/tb_video_fetch_ctrl.sv
// Self-checking bench for video_fetch_ctrl: vector table for the first refill, then
// directed sequences for latency, restarts, reset, disable and a short frame.
module tb_video_fetch_ctrl;

  localparam int AW = 30;

  logic          clk = 1'b0;
  logic          rst_n, enable, frame_start, bus_ack, rd_en;
  logic [AW-1:0] base_addr;
  logic [9:0]    fifo_level;
  logic          fifo_clear, fifo_wr, bus_req, frame_done, busy;
  logic [31:0]   fifo_wdata, bus_rdata;
  logic [AW-1:0] bus_addr;

  logic          enable_s, frame_start_s, bus_ack_s;
  logic [9:0]    fifo_level_s;
  logic          fifo_clear_s, fifo_wr_s, bus_req_s, frame_done_s, busy_s;
  logic [31:0]   fifo_wdata_s, bus_rdata_s;
  logic [AW-1:0] bus_addr_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return {2'b10, a} ^ 32'h1357_9BDF;
  endfunction

  assign bus_rdata   = mem_word(bus_addr);
  assign bus_rdata_s = mem_word(bus_addr_s);

  video_fetch_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .base_addr(base_addr),
    .frame_start(frame_start), .fifo_level(fifo_level), .fifo_clear(fifo_clear),
    .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata), .bus_req(bus_req), .bus_addr(bus_addr),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .frame_done(frame_done), .busy(busy)
  );

  video_fetch_ctrl #(.frame_words(20)) u_short (
    .clk(clk), .rst_n(rst_n), .enable(enable_s), .base_addr(base_addr),
    .frame_start(frame_start_s), .fifo_level(fifo_level_s), .fifo_clear(fifo_clear_s),
    .fifo_wr(fifo_wr_s), .fifo_wdata(fifo_wdata_s), .bus_req(bus_req_s), .bus_addr(bus_addr_s),
    .bus_ack(bus_ack_s), .bus_rdata(bus_rdata_s), .frame_done(frame_done_s), .busy(busy_s)
  );

  // FIFO occupancy models
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          fifo_level <= '0;
    else if (fifo_clear) fifo_level <= '0;
    else fifo_level <= fifo_level + 10'(fifo_wr) - 10'(rd_en && (fifo_level != 0));
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)            fifo_level_s <= '0;
    else if (fifo_clear_s) fifo_level_s <= '0;
    else                   fifo_level_s <= fifo_level_s + 10'(fifo_wr_s);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor for the main instance: every written word must be the next frame word.
  logic [AW-1:0] exp_addr = '0;
  int            wr_cnt   = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_clear) begin
        check("wr_during_clear", 32'(fifo_wr), 32'd0);
        exp_addr = base_addr;
      end else if (fifo_wr) begin
        check("wdata", fifo_wdata, mem_word(exp_addr));
        exp_addr = exp_addr + 1'b1;
        wr_cnt++;
      end
      check("level_bound", 32'(fifo_level <= 10'd512), 32'd1);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_req(input int max_cyc, input string name);
    int k;
    k = 0;
    while (!bus_req && k < max_cyc) begin
      cyc();
      k++;
    end
    check(name, 32'(bus_req), 32'd1);
  endtask

  typedef struct {
    logic          fs, en, ack;
    logic          req;
    logic [AW-1:0] addr;
    logic          wr, clr, bsy, done;
  } vec_t;

  vec_t tbl[16];

  task automatic set_row(input int i, input logic fs, input logic en, input logic ack,
                         input logic req, input logic [AW-1:0] addr, input logic wr,
                         input logic clr, input logic bsy, input logic done);
    tbl[i].fs = fs;   tbl[i].en = en;     tbl[i].ack = ack;
    tbl[i].req = req; tbl[i].addr = addr; tbl[i].wr = wr;
    tbl[i].clr = clr; tbl[i].bsy = bsy;   tbl[i].done = done;
  endtask

  initial begin
    logic [AW-1:0] a;
    logic          stable;
    int            idle, reqs, wr0, wrb;
    int            nb, nw, wlast, dfirst, req_after, lens[4];
    logic          prev;
    logic [AW-1:0] last_addr, exp_s;

    // First frame, one row per cycle: {fs,en,ack} driven, outputs expected during that cycle
    set_row(0,  0, 1, 0,  0, 30'h000, 0, 0, 0, 0);
    set_row(1,  1, 1, 0,  0, 30'h000, 0, 0, 0, 0);
    set_row(2,  0, 1, 0,  0, 30'h100, 0, 1, 1, 0);
    set_row(3,  0, 1, 0,  1, 30'h100, 0, 0, 1, 0);
    set_row(4,  0, 1, 1,  1, 30'h100, 0, 0, 1, 0);
    for (int i = 5; i <= 11; i++) set_row(i, 0, 1, 1, 1, 30'h100 + AW'(i - 4), 1, 0, 1, 0);
    set_row(12, 0, 1, 1,  0, 30'h108, 1, 0, 1, 0);
    set_row(13, 0, 1, 1,  0, 30'h108, 0, 0, 1, 0);
    set_row(14, 0, 1, 1,  1, 30'h108, 0, 0, 1, 0);
    set_row(15, 0, 1, 1,  1, 30'h109, 1, 0, 1, 0);

    rst_n = 1'b0; enable = 1'b0; frame_start = 1'b0; bus_ack = 1'b0; rd_en = 1'b0;
    base_addr = 30'h100; enable_s = 1'b0; frame_start_s = 1'b0; bus_ack_s = 1'b0;
    repeat (3) cyc();
    check("rst_req", 32'(bus_req), 0);       check("rst_addr", 32'(bus_addr), 0);
    check("rst_wr", 32'(fifo_wr), 0);        check("rst_wdata", fifo_wdata, 0);
    check("rst_clr", 32'(fifo_clear), 0);    check("rst_done", 32'(frame_done), 0);
    check("rst_busy", 32'(busy), 0);         check("rst_short_busy", 32'(busy_s), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      cyc();
      check($sformatf("vec%0d_req", i),  32'(bus_req),    32'(tbl[i].req));
      check($sformatf("vec%0d_addr", i), 32'(bus_addr),   32'(tbl[i].addr));
      check($sformatf("vec%0d_wr", i),   32'(fifo_wr),    32'(tbl[i].wr));
      check($sformatf("vec%0d_clr", i),  32'(fifo_clear), 32'(tbl[i].clr));
      check($sformatf("vec%0d_busy", i), 32'(busy),       32'(tbl[i].bsy));
      check($sformatf("vec%0d_done", i), 32'(frame_done), 32'(tbl[i].done));
      frame_start = tbl[i].fs;
      enable      = tbl[i].en;
      bus_ack     = tbl[i].ack;
    end

    // Basic refill: keep acking until the FIFO is full and requests stop
    idle = 0;
    for (int k = 0; k < 3000 && idle < 30; k++) begin
      cyc();
      if (bus_req) idle = 0;
      else         idle++;
    end
    check("refill_settled", 32'(idle >= 30), 1);
    check("refill_level", 32'(fifo_level), 512);
    check("refill_words", 32'(wr_cnt), 512);
    check("refill_next_addr", 32'(bus_addr), 32'h300);
    check("refill_busy", 32'(busy), 1);

    // Drain 7 words: room below one burst, so nothing is fetched
    rd_en = 1'b1;
    repeat (7) cyc();
    rd_en = 1'b0;
    reqs = 0;
    repeat (20) begin cyc(); if (bus_req) reqs++; end
    check("room7_no_req", 32'(reqs), 0);
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    wait_req(6, "room8_req");
    idle = 0;
    for (int k = 0; k < 100 && idle < 20; k++) begin
      cyc();
      if (bus_req) idle = 0;
      else         idle++;
    end
    check("room8_level", 32'(fifo_level), 512);
    check("room8_words", 32'(wr_cnt), 520);
    check("room8_next_addr", 32'(bus_addr), 32'h308);

    // Ack latency: every beat waits 5 cycles for its ack
    bus_ack = 1'b0; base_addr = 30'h1000; frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    wr0 = wr_cnt;
    for (int b = 0; b < 8; b++) begin
      wait_req(10, "lat_req");
      a = bus_addr;
      check("lat_addr", 32'(a), 32'h1000 + 32'(b));
      stable = 1'b1;
      for (int k = 0; k < 5; k++) begin
        cyc();
        if (!bus_req || bus_addr != a) stable = 1'b0;
      end
      check("lat_stable", 32'(stable), 1);
      bus_ack = 1'b1;
      cyc();
      bus_ack = 1'b0;
    end
    repeat (6) cyc();
    check("lat_writes", 32'(wr_cnt - wr0), 8);
    check("lat_req_held", 32'(bus_req), 1);
    check("lat_addr_held", 32'(bus_addr), 32'h1008);

    // Mid-burst restart with ack pending; a second pulse during FLUSH is absorbed
    wrb = wr_cnt;
    base_addr = 30'h2000; frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    check("flush_req", 32'(bus_req), 1);   check("flush_addr", 32'(bus_addr), 32'h1008);
    check("flush_clr", 32'(fifo_clear), 0);
    cyc();
    frame_start = 1'b1;
    check("flush_req2", 32'(bus_req), 1);  check("flush_addr2", 32'(bus_addr), 32'h1008);
    cyc();
    frame_start = 1'b0;
    check("flush_req3", 32'(bus_req), 1);  check("flush_clr3", 32'(fifo_clear), 0);
    bus_ack = 1'b1;
    cyc();
    bus_ack = 1'b0;
    check("flush_end_clr", 32'(fifo_clear), 1);  check("flush_end_wr", 32'(fifo_wr), 0);
    check("flush_end_req", 32'(bus_req), 0);     check("flush_end_addr", 32'(bus_addr), 32'h2000);
    cyc();
    check("restart_req", 32'(bus_req), 1);       check("restart_addr", 32'(bus_addr), 32'h2000);
    check("restart_single_clr", 32'(fifo_clear), 0);
    check("flush_no_write", 32'(wr_cnt - wrb), 0);

    // frame_start coinciding with an ack: that word is dropped
    bus_ack = 1'b1; frame_start = 1'b1; base_addr = 30'h3000;
    cyc();
    bus_ack = 1'b0; frame_start = 1'b0;
    check("sim_clr", 32'(fifo_clear), 1);  check("sim_wr", 32'(fifo_wr), 0);
    check("sim_req", 32'(bus_req), 0);     check("sim_addr", 32'(bus_addr), 32'h3000);
    cyc();
    check("sim_restart_req", 32'(bus_req), 1);
    check("sim_restart_addr", 32'(bus_addr), 32'h3000);

    // Asynchronous reset in the middle of a burst
    bus_ack = 1'b1;
    cyc();
    cyc();
    check("pre_rst_wr", 32'(fifo_wr), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req", 32'(bus_req), 0);     check("arst_addr", 32'(bus_addr), 0);
    check("arst_wr", 32'(fifo_wr), 0);      check("arst_wdata", fifo_wdata, 0);
    check("arst_clr", 32'(fifo_clear), 0);  check("arst_done", 32'(frame_done), 0);
    check("arst_busy", 32'(busy), 0);
    bus_ack = 1'b0;
    cyc();
    rst_n = 1'b1;

    // Disable during a burst: pending handshake completes and is written
    base_addr = 30'h400; frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    wait_req(5, "dis_req");
    check("dis_addr", 32'(bus_addr), 32'h400);
    enable = 1'b0;
    cyc();
    check("dis_req_held", 32'(bus_req), 1);  check("dis_busy", 32'(busy), 1);
    cyc();
    check("dis_req_held2", 32'(bus_req), 1);
    wrb = wr_cnt;
    bus_ack = 1'b1;
    cyc();
    bus_ack = 1'b0;
    check("dis_wr", 32'(fifo_wr), 1);        check("dis_req_drop", 32'(bus_req), 0);
    check("dis_idle", 32'(busy), 0);         check("dis_one_write", 32'(wr_cnt - wrb), 1);
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    check("dis_fs_clr", 32'(fifo_clear), 0);
    cyc();
    check("dis_fs_busy", 32'(busy), 0);      check("dis_fs_req", 32'(bus_req), 0);

    // Short frame of 20 words on the second instance
    base_addr = 30'h500; enable_s = 1'b1; bus_ack_s = 1'b1; frame_start_s = 1'b1;
    cyc();
    frame_start_s = 1'b0;
    check("short_clr", 32'(fifo_clear_s), 1);
    exp_s = 30'h500; nb = 0; nw = 0; wlast = -1; dfirst = -1; req_after = 0; prev = 1'b0;
    last_addr = '0;
    for (int i = 0; i < 4; i++) lens[i] = 0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (bus_req_s) begin
        if (!prev) nb++;
        if (nb >= 1 && nb <= 4) lens[nb-1]++;
        last_addr = bus_addr_s;
        if (dfirst >= 0) req_after++;
      end
      prev = bus_req_s;
      if (fifo_wr_s) begin
        check("short_wdata", fifo_wdata_s, mem_word(exp_s));
        exp_s = exp_s + 1'b1;
        nw++;
        if (nw == 20) wlast = i;
      end
      if (frame_done_s && dfirst < 0) dfirst = i;
    end
    check("short_bursts", 32'(nb), 3);
    check("short_len0", 32'(lens[0]), 8);
    check("short_len1", 32'(lens[1]), 8);
    check("short_len2", 32'(lens[2]), 4);
    check("short_words", 32'(nw), 20);
    check("short_last_addr", 32'(last_addr), 32'h513);
    check("short_done_timing", 32'(dfirst), 32'(wlast + 1));
    check("short_done", 32'(frame_done_s), 1);
    check("short_no_req_after", 32'(req_after), 0);
    check("short_not_busy", 32'(busy_s), 0);
    frame_start_s = 1'b1;
    cyc();
    frame_start_s = 1'b0; enable_s = 1'b0;
    check("short_restart_clr", 32'(fifo_clear_s), 1);
    check("short_restart_done", 32'(frame_done_s), 0);
    check("short_restart_busy", 32'(busy_s), 1);
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
